// File: rtl/counter_event_capture_if.sv
// Event drain channel from the capture block to its consumer.
// valid/ready: a record transfers on a rising clk edge where ev_valid and
// ev_ready are both high. While ev_valid is high and ev_ready is low, ev_data
// holds steady. While ev_valid is low, ev_ready has no effect.
interface counter_event_capture_if #(
    parameter int WIDTH = 16
);
    logic             ev_valid;
    logic [WIDTH+1:0] ev_data;
    logic             ev_ready;

    modport master (output ev_valid, output ev_data, input ev_ready);
    modport slave  (input ev_valid, input ev_data, output ev_ready);
endinterface

// File: rtl/counter_event_capture.sv
// Monitors an upstream counter for compare-match, rollover and clear events.
// Each detected event becomes a tagged record {type, count} in a small FIFO
// that is drained over the valid/ready channel in ev.
module counter_event_capture #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      count,
    input  logic [WIDTH-1:0]      cmp_value,
    input  logic                  cmp_load,
    counter_event_capture_if.master ev,
    output logic                  match_pulse,
    output logic                  overflow,
    input  logic                  clear_ovf
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] prev_count;
    logic             prev_valid;
    logic [WIDTH-1:0] cmp_reg;
    logic [WIDTH+1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    logic       changed;
    logic       ro;
    logic       cl;
    logic       m;
    logic       push;
    logic       pop;
    logic       full;
    logic       empty;
    logic       push_ok;
    logic [1:0] ev_type;

    // Event detection against the previous sample; gated until the first sample is held.
    assign changed = prev_valid && (count != prev_count);
    assign ro      = changed && (prev_count == {WIDTH{1'b1}}) && (count == '0);
    assign cl      = changed && (count == '0) && !ro;
    assign m       = changed && (count == cmp_reg);
    assign push    = ro || m || cl;

    // Rollover dominates; the low bit of a rollover record carries the match flag.
    assign ev_type = ro ? {1'b1, m} : (m ? 2'b01 : 2'b00);

    // Extra pointer MSB distinguishes full from empty when the indices coincide.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = !empty && ev.ev_ready;
    // A pop in the same cycle frees the slot the write lands in.
    assign push_ok = push && (!full || pop);

    assign ev.ev_valid = !empty;
    assign ev.ev_data  = mem[rd_ptr[AW-1:0]];

    // Previous-sample register and its valid flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_count <= '0;
            prev_valid <= 1'b0;
        end else begin
            prev_count <= count;
            prev_valid <= 1'b1;
        end
    end

    // Compare register; a newly loaded value takes effect the cycle after the load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmp_reg <= '0;
        end else if (cmp_load) begin
            cmp_reg <= cmp_value;
        end
    end

    // FIFO storage and pointers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= {ev_type, count};
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // One-cycle match pulse, independent of FIFO acceptance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            match_pulse <= 1'b0;
        end else begin
            match_pulse <= m;
        end
    end

    // Sticky drop flag; a drop in the same cycle wins over a clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (push && !push_ok) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_counter_event_capture.sv
// Self-checking bench for counter_event_capture: a scoreboard queue holds the
// records expected from each counter sequence, popped on every handshake.
module tb_counter_event_capture;
  localparam int W  = 16;
  localparam int D  = 4;
  localparam int RW = W + 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [W-1:0]  count;
  logic [W-1:0]  cmp_value;
  logic          cmp_load;
  logic          clear_ovf;
  logic          match_pulse;
  logic          overflow;

  counter_event_capture_if #(.WIDTH(W)) ev_if ();

  counter_event_capture #(.WIDTH(W), .DEPTH(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .count       (count),
    .cmp_value   (cmp_value),
    .cmp_load    (cmp_load),
    .ev          (ev_if),
    .match_pulse (match_pulse),
    .overflow    (overflow),
    .clear_ovf   (clear_ovf)
  );

  // scoreboard
  logic [RW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // every accepted record is compared against the head of the expected queue
  always @(negedge clk) begin
    if (ev_if.ev_valid && ev_if.ev_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_record", 32'(ev_if.ev_data), 32'hFFFF_FFFF);
      end else begin
        check("record", 32'(ev_if.ev_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic step(input logic [W-1:0] v);
    @(posedge clk);
    #1;
    count = v;
  endtask

  task automatic load_cmp(input logic [W-1:0] v);
    @(posedge clk);
    #1;
    cmp_value = v;
    cmp_load  = 1'b1;
    @(posedge clk);
    #1;
    cmp_load  = 1'b0;
  endtask

  logic [W-1:0] v;

  initial begin
    reset          = 1'b0;
    count          = 16'h1234;
    cmp_value      = '0;
    cmp_load       = 1'b0;
    clear_ovf      = 1'b0;
    ev_if.ev_ready = 1'b1;

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ev_valid", 32'(ev_if.ev_valid), 32'd0);
    check("rst_ev_data", 32'(ev_if.ev_data), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_match_pulse", 32'(match_pulse), 32'd0);

    // release with count dropping to 0: first sample only loads prev_count
    @(posedge clk);
    #1;
    reset = 1'b1;
    count = '0;
    step(16'd1);
    step(16'd2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_rec_after_reset", 32'(ev_if.ev_valid), 32'd0);
    end

    // compare match at 5
    load_cmp(16'h0005);
    step(16'd3);
    step(16'd4);
    step(16'd5);
    exp_q.push_back({2'b01, 16'h0005});
    @(posedge clk);
    @(negedge clk);
    check("match_pulse_hi", 32'(match_pulse), 32'd1);
    check("match_valid_hi", 32'(ev_if.ev_valid), 32'd1);
    step(16'd6);
    @(negedge clk);
    check("match_pulse_lo", 32'(match_pulse), 32'd0);
    check("match_valid_lo", 32'(ev_if.ev_valid), 32'd0);
    step(16'd7);
    step(16'd8);

    // rollover with cmp_reg = 0 -> rollover+match
    load_cmp(16'h0000);
    step(16'hFFFE);
    step(16'hFFFF);
    step(16'h0000);
    exp_q.push_back({2'b11, 16'h0000});
    @(posedge clk);
    @(negedge clk);
    check("ro_match_valid", 32'(ev_if.ev_valid), 32'd1);

    // rollover with cmp_reg = 7 -> rollover only
    load_cmp(16'h0007);
    step(16'hFFFE);
    step(16'hFFFF);
    step(16'h0000);
    exp_q.push_back({2'b10, 16'h0000});

    // counter clear from 0x1234
    step(16'h1234);
    step(16'h0000);
    exp_q.push_back({2'b00, 16'h0000});
    repeat (2) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("static_no_rec", 32'(ev_if.ev_valid), 32'd0);
    end

    // fill with ev_ready low: DEPTH kept, one dropped
    ev_if.ev_ready = 1'b0;
    for (int i = 0; i <= D; i++) begin
      v = 16'(16'h0100 * (i + 1)) + 16'($urandom_range(0, 255));
      load_cmp(v);
      if (i == D) begin
        @(negedge clk);
        check("ovf_before_drop", 32'(overflow), 32'd0);
      end
      step(v);
      if (i < D) exp_q.push_back({2'b01, v});
    end
    @(posedge clk);
    @(negedge clk);
    check("ovf_set", 32'(overflow), 32'd1);

    // drain in push order
    @(posedge clk);
    #1;
    ev_if.ev_ready = 1'b1;
    repeat (D + 2) @(posedge clk);
    @(negedge clk);
    check("drained_valid", 32'(ev_if.ev_valid), 32'd0);
    check("drained_all", 32'(exp_q.size()), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);
    @(posedge clk);
    #1;
    clear_ovf = 1'b1;
    @(posedge clk);
    #1;
    clear_ovf = 1'b0;
    @(negedge clk);
    check("ovf_cleared", 32'(overflow), 32'd0);

    // full FIFO with simultaneous push and pop
    ev_if.ev_ready = 1'b0;
    for (int i = 0; i < D; i++) begin
      v = 16'(16'h2000 + 16'h0100 * i) + 16'($urandom_range(0, 255));
      load_cmp(v);
      step(v);
      exp_q.push_back({2'b01, v});
    end
    v = 16'h3000 + 16'($urandom_range(0, 255));
    load_cmp(v);
    @(posedge clk);
    #1;
    count          = v;
    ev_if.ev_ready = 1'b1;
    exp_q.push_back({2'b01, v});
    @(posedge clk);
    #1;
    ev_if.ev_ready = 1'b0;
    @(negedge clk);
    check("pushpop_no_ovf", 32'(overflow), 32'd0);
    check("pushpop_valid", 32'(ev_if.ev_valid), 32'd1);

    // occupancy still DEPTH: the next event must be dropped
    v = 16'h4000 + 16'($urandom_range(0, 255));
    load_cmp(v);
    step(v);
    @(posedge clk);
    @(negedge clk);
    check("full_drop_ovf", 32'(overflow), 32'd1);

    // reset in the middle of a drain
    @(posedge clk);
    #1;
    ev_if.ev_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_mid_valid", 32'(ev_if.ev_valid), 32'd0);
    check("rst_mid_overflow", 32'(overflow), 32'd0);
    check("rst_mid_match_pulse", 32'(match_pulse), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
